cache_ctrl: RTL
===============

# cache_ctrl

Parametrised cache controller FSM sitting between the CPU memory port and the cache tag/data arrays plus the backing RAM. Supersedes the single-word, fixed-latency controller: supports multi-word line refill, a real request/acknowledge handshake to RAM of arbitrary latency, write-through with optional write-allocate, and saturating hit/miss counters. Cache arrays and RAM remain external; this block only sequences them.

## Interface

Parameters:
- WORDS_PER_LINE, 4, words per cache line; power of two, 1..64
- CNT_W, 16, width of hit/miss counters

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- read  in  1  CPU read request, level, held until ready
- write  in  1  CPU write request, level, held until ready
- hit  in  1  tag compare result, valid in LOOKUP
- ready  out  1  one-cycle completion pulse to CPU
- update_tag  out  1  one-cycle pulse: write new tag/valid for missing line
- update_cache  out  1  one-cycle pulse: write data word into cache
- word_idx  out  WI_W  word within line for refill/update (WI_W = max(1, clog2(WORDS_PER_LINE)))
- ram_read  out  1  RAM read request, held until ram_ack
- ram_write  out  1  RAM write request, held until ram_ack
- ram_ack  in  1  RAM completion, one-cycle pulse
- hit_count  out  CNT_W  saturating lookup-hit counter
- miss_count  out  CNT_W  saturating lookup-miss counter

## Operation

- States: IDLE, LOOKUP, REFILL, WRITE_RAM, DONE.
- IDLE: read=1 -> LOOKUP (op=read); else write=1 -> LOOKUP (op=write). Read and write both high: read wins.
- LOOKUP, op=read: hit -> DONE, hit_count++. Miss -> update_tag=1 this cycle, word_idx<=0, miss_count++, -> REFILL.
- LOOKUP, op=write: hit -> update_cache=1 this cycle, hit_count++; miss -> miss_count++ (no cache update). Both -> WRITE_RAM.
- REFILL: ram_read=1 with current word_idx. On ram_ack: update_cache=1 same cycle (Mealy), word_idx increments; ack on last word (WORDS_PER_LINE-1) -> DONE, word_idx wraps to 0.
- WRITE_RAM: ram_write=1 until ram_ack, then -> DONE.
- DONE: ready=1, -> IDLE.
- Request dropped in LOOKUP: -> IDLE, no outputs, counters unchanged. Dropped during REFILL/WRITE_RAM: RAM transaction completes (never aborted); DONE skipped, ready not asserted, -> IDLE.
- ram_ack outside REFILL/WRITE_RAM: ignored.
- Counters saturate at all-ones; never wrap.
- Reset (any time, asynchronous): state IDLE, ready/update_tag/update_cache/ram_read/ram_write=0, word_idx=0, hit_count=miss_count=0. Mid-refill reset leaves the line partially filled; tag validity is the array's concern.

## Timing

- ready, ram_read, ram_write: decoded from state only (Moore). update_tag, update_cache: state plus hit/ram_ack (Mealy).
- Read hit: request seen in IDLE at cycle 0, LOOKUP cycle 1, ready in cycle 2; 3 cycles total.
- Read miss, ack latency L per word: ready at cycle 2 + WORDS_PER_LINE*(L+1).
- Write (hit or miss), ack latency L: ready at cycle 3 + L.
- Zero-latency RAM (ack in first request cycle) supported: L=0.
- Back-to-back: new request accepted in the IDLE cycle after DONE; minimum one idle cycle between ready pulses.

## Configuration

- CACHE_CTRL_WRITE_ALLOCATE_EN defined: write miss in LOOKUP asserts update_tag, -> REFILL; after last refill ack, one cycle with update_cache=1 (word_idx=0, CPU word merge), then -> WRITE_RAM. Adds state ALLOC_MERGE.
- Undefined: write-no-allocate as described in Operation; ALLOC_MERGE absent.

## Structure

- Package cache_ctrl_pkg: state encodings (3-bit localparams), op encoding, WI_W derivation function.
- Sub-module cache_sat_counter (CNT_W parameter, inc, async active-low clear), instantiated twice for hit_count/miss_count.

## Test plan

- Reset, WORDS_PER_LINE=4: read=1, hit=1 -> ready at cycle 2, hit_count=1, no ram_read.
- Read miss, ack latency 2 -> update_tag cycle 1; update_cache with word_idx 0,1,2,3 on each ack; ready at cycle 14; miss_count=1.
- Write hit, latency 0 -> update_cache in LOOKUP, ram_write one cycle, ready at cycle 3; write miss without macro -> no update_cache, no update_tag.
- read and write high together -> read path taken; drop read during REFILL -> all 4 acks consumed, no ready, back to IDLE.
- CNT_W=2: five hits -> hit_count stays 3; reset asserted mid-REFILL -> all outputs 0 immediately, word_idx=0.
- With CACHE_CTRL_WRITE_ALLOCATE_EN: write miss -> update_tag, 4-word refill, merge update_cache, ram_write, ready.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// Shared encodings for the cache controller FSM.
// CACHE_CTRL_WRITE_ALLOCATE_EN adds the ALLOC_MERGE state.
package cache_ctrl_pkg;

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_LOOKUP      = 3'd1;
    localparam logic [2:0] ST_REFILL      = 3'd2;
    localparam logic [2:0] ST_WRITE_RAM   = 3'd3;
    localparam logic [2:0] ST_DONE        = 3'd4;
`ifdef CACHE_CTRL_WRITE_ALLOCATE_EN
    localparam logic [2:0] ST_ALLOC_MERGE = 3'd5;
`endif

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_LOOKUP    = ST_LOOKUP,
        S_REFILL    = ST_REFILL,
        S_WRITE_RAM = ST_WRITE_RAM,
        S_DONE      = ST_DONE
`ifdef CACHE_CTRL_WRITE_ALLOCATE_EN
        , S_ALLOC_MERGE = ST_ALLOC_MERGE
`endif
    } state_t;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    // A one-word line still needs a one-bit index port.
    function automatic int wi_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cache_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module cache_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clock,
    input  logic             i_clear_n,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clock or negedge i_clear_n) begin
        if (!i_clear_n)
            r_count <= '0;
        else if (i_inc && (r_count != '1))
            r_count <= r_count + 1'b1;
    end

    assign o_count = r_count;

endmodule

// File: rtl/cache_ctrl.sv
// Cache controller: lookup, multi-word refill, write-through to RAM, hit/miss stats.
// Define CACHE_CTRL_WRITE_ALLOCATE_EN to refill and merge on write misses.
module cache_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter  int WORDS_PER_LINE = 4,
    parameter  int CNT_W          = 16,
    localparam int WI_W           = wi_width(WORDS_PER_LINE)
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_read,
    input  logic             i_write,
    input  logic             i_hit,
    output logic             o_ready,
    output logic             o_update_tag,
    output logic             o_update_cache,
    output logic [WI_W-1:0]  o_word_idx,
    output logic             o_ram_read,
    output logic             o_ram_write,
    input  logic             i_ram_ack,
    output logic [CNT_W-1:0] o_hit_count,
    output logic [CNT_W-1:0] o_miss_count
);

    localparam logic [WI_W-1:0] LAST_IDX = WI_W'(WORDS_PER_LINE - 1);

    state_t          r_state, w_next;
    logic            r_op, w_op_nxt;
    logic            r_drop, w_drop_nxt;
    logic [WI_W-1:0] r_word_idx, w_word_idx_nxt;
    logic            w_req, w_dropped, w_hit_inc, w_miss_inc;

    assign w_req     = (r_op == OP_WRITE) ? i_write : i_read;
    // Sticky once the CPU lets go: the RAM transfer still finishes, but no ready.
    assign w_dropped = r_drop | ~w_req;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= S_IDLE;
            r_op       <= OP_READ;
            r_drop     <= 1'b0;
            r_word_idx <= '0;
        end else begin
            r_state    <= w_next;
            r_op       <= w_op_nxt;
            r_drop     <= w_drop_nxt;
            r_word_idx <= w_word_idx_nxt;
        end
    end

    always_comb begin
        w_next         = r_state;
        w_op_nxt       = r_op;
        w_drop_nxt     = r_drop;
        w_word_idx_nxt = r_word_idx;
        o_update_tag   = 1'b0;
        o_update_cache = 1'b0;
        w_hit_inc      = 1'b0;
        w_miss_inc     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_drop_nxt = 1'b0;
                if (i_read) begin
                    w_op_nxt = OP_READ;
                    w_next   = S_LOOKUP;
                end else if (i_write) begin
                    w_op_nxt = OP_WRITE;
                    w_next   = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (!w_req) begin
                    w_next = S_IDLE;
                end else if (i_hit) begin
                    w_hit_inc = 1'b1;
                    if (r_op == OP_WRITE) begin
                        o_update_cache = 1'b1;
                        w_next         = S_WRITE_RAM;
                    end else begin
                        w_next = S_DONE;
                    end
                end else begin
                    w_miss_inc = 1'b1;
                    if (r_op == OP_READ) begin
                        o_update_tag   = 1'b1;
                        w_word_idx_nxt = '0;
                        w_next         = S_REFILL;
                    end else begin
`ifdef CACHE_CTRL_WRITE_ALLOCATE_EN
                        o_update_tag   = 1'b1;
                        w_word_idx_nxt = '0;
                        w_next         = S_REFILL;
`else
                        w_next = S_WRITE_RAM;
`endif
                    end
                end
            end
            S_REFILL: begin
                w_drop_nxt = w_dropped;
                if (i_ram_ack) begin
                    o_update_cache = 1'b1;
                    if (r_word_idx == LAST_IDX) begin
                        w_word_idx_nxt = '0;
                        if (w_dropped)
                            w_next = S_IDLE;
`ifdef CACHE_CTRL_WRITE_ALLOCATE_EN
                        else if (r_op == OP_WRITE)
                            w_next = S_ALLOC_MERGE;
`endif
                        else
                            w_next = S_DONE;
                    end else begin
                        w_word_idx_nxt = r_word_idx + 1'b1;
                    end
                end
            end
`ifdef CACHE_CTRL_WRITE_ALLOCATE_EN
            S_ALLOC_MERGE: begin
                if (!w_req) begin
                    w_next = S_IDLE;
                end else begin
                    o_update_cache = 1'b1;
                    w_next         = S_WRITE_RAM;
                end
            end
`endif
            S_WRITE_RAM: begin
                w_drop_nxt = w_dropped;
                if (i_ram_ack)
                    w_next = w_dropped ? S_IDLE : S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign o_ready     = (r_state == S_DONE);
    assign o_ram_read  = (r_state == S_REFILL);
    assign o_ram_write = (r_state == S_WRITE_RAM);
    assign o_word_idx  = r_word_idx;

    cache_sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .i_clock   (i_clock),
        .i_clear_n (i_reset_n),
        .i_inc     (w_hit_inc),
        .o_count   (o_hit_count)
    );

    cache_sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .i_clock   (i_clock),
        .i_clear_n (i_reset_n),
        .i_inc     (w_miss_inc),
        .o_count   (o_miss_count)
    );

endmodule
